fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have a parameter BUBBLES, default 2, giving the number of flush cycles per redirect (legal range 1..7).
REQ-002 The block SHALL have a parameter NOP, default 12'h000, giving the instruction word injected on flush (downstream use only, no internal effect).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 The block SHALL have port branch_taken_e, input, 1 bit: a taken branch or jump is resolved in EX this cycle.
REQ-006 The block SHALL have port branch_target_e, input, 12 bits: the resolved target PC, valid when branch_taken_e=1.
REQ-007 The block SHALL have port stall_req, input, 1 bit: a downstream stage (e.g. a multicycle vector op) requests that fetch hold.
REQ-008 The block SHALL have port halt_d, input, 1 bit: decode holds a HALT opcode.
REQ-009 The block SHALL have port resume, input, 1 bit: external restart from HALT.
REQ-010 The block SHALL have port pc_en, output, 1 bit: the PC register load enable.
REQ-011 The block SHALL have port PCSrcE, output, 1 bit: PC mux select (1 = jumpPC).
REQ-012 The block SHALL have port jumpPC, output, 12 bits: the redirect target sent to the PC mux.
REQ-013 The block SHALL have port stop, output, 1 bit: hold the IF/ID register.
REQ-014 The block SHALL have port flush, output, 1 bit: load NOP into the IF/ID register.
REQ-015 The block SHALL have port state_o, output, 3 bits: current FSM state (debug).
REQ-016 The block SHALL have port redirect_cnt, output, 8 bits: count of accepted redirects.

Function
REQ-017 The FSM states SHALL be BOOT=0, RUN=1, STALL=2, FLUSH=3, HALT=4; state_o SHALL equal the registered state.
REQ-018 All outputs except state_o and redirect_cnt SHALL be Mealy, decoded combinationally from the state and the current inputs; all internal storage SHALL update on the rising edge of clk.
REQ-019 BOOT SHALL drive pc_en=0, flush=1, stop=0, and SHALL go to RUN unconditionally after one cycle, covering invalid synchronous IMem output.
REQ-020 Event priority in RUN, STALL and FLUSH SHALL be branch_taken_e > halt_d > stall_req.
REQ-021 A branch is accepted when branch_taken_e=1 in RUN, STALL or FLUSH; that same cycle PCSrcE=1, jumpPC=branch_target_e, pc_en=1, flush=1, stop=0.
REQ-022 An accepted branch SHALL load a bubble counter with BUBBLES-1; next state SHALL be FLUSH if BUBBLES>1, else RUN.
REQ-023 FLUSH SHALL drive flush=1, pc_en=1 and decrement the counter each cycle, going to RUN in the cycle after the counter reads 0; total flush cycles per redirect SHALL be exactly BUBBLES.
REQ-024 A new branch accepted in FLUSH SHALL reload the counter and restart the BUBBLES count.
REQ-025 When not accepting a branch, PCSrcE SHALL be 0 and jumpPC SHALL be 12'h000.
REQ-026 In RUN, stall_req=1 with no higher-priority event SHALL give pc_en=0 and stop=1 that same cycle, with next state STALL.
REQ-027 STALL SHALL hold pc_en=0 and stop=1 while stall_req=1, and SHALL return to RUN (pc_en=1, stop=0) in the first cycle with stall_req=0.
REQ-028 In FLUSH, stall_req SHALL be ignored.
REQ-029 In RUN or STALL, halt_d=1 with no branch SHALL give pc_en=0, flush=1 that cycle, with next state HALT.
REQ-030 HALT SHALL hold pc_en=0, stop=1, flush=0, and SHALL ignore branch_taken_e, halt_d and stall_req.
REQ-031 HALT SHALL go to RUN on the cycle after resume=1.
REQ-032 In RUN with no event, outputs SHALL be pc_en=1, stop=0, flush=0.
REQ-033 redirect_cnt SHALL increment by 1 per accepted branch and saturate at 255.
REQ-034 stop and flush SHALL never both be 1.

Reset
REQ-035 rst=0 SHALL immediately, independent of clk, force state BOOT, bubble counter 0 and redirect_cnt 0; during reset pc_en=0, PCSrcE=0, jumpPC=12'h000, stop=0, flush=1.
REQ-036 Reset asserted mid-FLUSH, mid-STALL or mid-HALT SHALL abandon the operation with no residual count.
REQ-037 The first edge after rst rises SHALL be spent in BOOT.

Verification
REQ-038 Release reset, no events -> one BOOT cycle (flush=1, pc_en=0), then RUN with pc_en=1 every cycle.
REQ-039 In RUN, pulse branch_taken_e with target 12'h0A5 -> same cycle PCSrcE=1, jumpPC=12'h0A5; flush=1 for exactly 2 cycles; redirect_cnt=1.
REQ-040 Hold stall_req for 3 cycles, with a branch to 12'h010 in the 2nd cycle -> branch accepted in that cycle, stall dropped, FLUSH entered.
REQ-041 halt_d and branch_taken_e together -> branch wins; halt_d alone -> HALT with pc_en=0 until resume, then RUN on the following cycle.
REQ-042 Issue 260 redirects -> redirect_cnt stays at 255.
REQ-043 Assert rst in the 1st FLUSH cycle -> outputs reach their reset values without a clk edge; after release, BOOT then RUN with no further flush.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch-stage control FSM: PC enable, branch redirect with flush bubbles, stall and halt handling.
// Control outputs are decoded combinationally from the registered state and current inputs.
module fetch_ctrl #(
  parameter int unsigned BUBBLES = 2,
  parameter logic [11:0] NOP     = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken_e,
  input  logic [11:0] branch_target_e,
  input  logic        stall_req,
  input  logic        halt_d,
  input  logic        resume,
  output logic        pc_en,
  output logic        PCSrcE,
  output logic [11:0] jumpPC,
  output logic        stop,
  output logic        flush,
  output logic [2:0]  state_o,
  output logic [7:0]  redirect_cnt
);

  typedef enum logic [2:0] {
    StBoot  = 3'd0,
    StRun   = 3'd1,
    StStall = 3'd2,
    StFlush = 3'd3,
    StHalt  = 3'd4
  } state_e;

  localparam logic [2:0] BubLoad = 3'(BUBBLES - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] redirect_cnt_q, redirect_cnt_d;
  logic       accept;

  // NOP only matters to the IF/ID register downstream.
  logic unused_nop;
  assign unused_nop = ^NOP;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    pc_en   = 1'b0;
    PCSrcE  = 1'b0;
    jumpPC  = 12'h000;
    stop    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      StBoot: begin
        flush   = 1'b1;
        state_d = StRun;
      end
      StRun, StStall, StFlush: begin
        if (branch_taken_e) begin
          accept  = 1'b1;
          pc_en   = 1'b1;
          PCSrcE  = 1'b1;
          jumpPC  = branch_target_e;
          flush   = 1'b1;
          cnt_d   = BubLoad;
          state_d = (BUBBLES > 1) ? StFlush : StRun;
        end else if (halt_d && (state_q != StFlush)) begin
          flush   = 1'b1;
          state_d = StHalt;
        end else if (state_q == StFlush) begin
          // The redirect cycle itself counts as the first bubble.
          pc_en   = 1'b1;
          flush   = 1'b1;
          cnt_d   = (cnt_q != 3'd0) ? cnt_q - 3'd1 : 3'd0;
          state_d = (cnt_q <= 3'd1) ? StRun : StFlush;
        end else if (stall_req) begin
          stop    = 1'b1;
          state_d = StStall;
        end else begin
          pc_en   = 1'b1;
          state_d = StRun;
        end
      end
      StHalt: begin
        stop = 1'b1;
        if (resume) state_d = StRun;
      end
      default: begin
        flush   = 1'b1;
        state_d = StBoot;
      end
    endcase
  end

  always_comb begin
    redirect_cnt_d = redirect_cnt_q;
    if (accept && (redirect_cnt_q != 8'hFF)) redirect_cnt_d = redirect_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StBoot;
      cnt_q          <= 3'd0;
      redirect_cnt_q <= 8'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign state_o      = state_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with default BUBBLES=2; checks Mealy outputs mid-cycle.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        branch_taken_e;
  logic [11:0] branch_target_e;
  logic        stall_req;
  logic        halt_d;
  logic        resume;
  logic        pc_en;
  logic        PCSrcE;
  logic [11:0] jumpPC;
  logic        stop;
  logic        flush;
  logic [2:0]  state_o;
  logic [7:0]  redirect_cnt;

  int checks = 0;
  int errors = 0;

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .branch_taken_e (branch_taken_e),
    .branch_target_e(branch_target_e),
    .stall_req      (stall_req),
    .halt_d         (halt_d),
    .resume         (resume),
    .pc_en          (pc_en),
    .PCSrcE         (PCSrcE),
    .jumpPC         (jumpPC),
    .stop           (stop),
    .flush          (flush),
    .state_o        (state_o),
    .redirect_cnt   (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_en, PCSrcE, jumpPC, stop, flush, state}
  function automatic logic [18:0] ev(input logic pe, input logic ps, input logic [11:0] jp,
                                     input logic st, input logic fl, input logic [2:0] s);
    return {pe, ps, jp, st, fl, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [18:0] exp);
    chk(tag, 32'({pc_en, PCSrcE, jumpPC, stop, flush, state_o}), 32'(exp));
  endtask

  task automatic drive(input logic bt, input logic [11:0] tgt, input logic st,
                       input logic h, input logic r);
    branch_taken_e  = bt;
    branch_target_e = tgt;
    stall_req       = st;
    halt_d          = h;
    resume          = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk_out("reset_outs", ev(0, 0, 12'h000, 0, 1, 3'd0));
    chk("reset_cnt", 32'(redirect_cnt), 32'd0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_out("boot", ev(0, 0, 12'h000, 0, 1, 3'd0));
    tick(); drive(0, 12'h000, 0, 0, 0);
    chk_out("run_idle0", ev(1, 0, 12'h000, 0, 0, 3'd1));
    tick(); drive(0, 12'h000, 0, 0, 0);
    chk_out("run_idle1", ev(1, 0, 12'h000, 0, 0, 3'd1));

    // Branch from RUN: two flush cycles in total.
    drive(1, 12'h0A5, 0, 0, 0);
    chk_out("br_accept", ev(1, 1, 12'h0A5, 0, 1, 3'd1));
    tick(); drive(0, 12'h0A5, 0, 0, 0);
    chk_out("br_flush2", ev(1, 0, 12'h000, 0, 1, 3'd3));
    chk("br_cnt1", 32'(redirect_cnt), 32'd1);
    tick(); drive(0, 12'h000, 0, 0, 0);
    chk_out("br_back_run", ev(1, 0, 12'h000, 0, 0, 3'd1));

    // Stall for three cycles, branch in the second.
    drive(0, 12'h000, 1, 0, 0);
    chk_out("stall_c1", ev(0, 0, 12'h000, 1, 0, 3'd1));
    tick(); drive(1, 12'h010, 1, 0, 0);
    chk_out("stall_br", ev(1, 1, 12'h010, 0, 1, 3'd2));
    tick(); drive(0, 12'h000, 1, 0, 0);
    chk_out("stall_ign_flush", ev(1, 0, 12'h000, 0, 1, 3'd3));
    chk("stall_cnt2", 32'(redirect_cnt), 32'd2);
    tick(); drive(0, 12'h000, 0, 0, 0);
    chk_out("stall_br_run", ev(1, 0, 12'h000, 0, 0, 3'd1));

    // Plain stall then release.
    drive(0, 12'h000, 1, 0, 0);
    tick(); drive(0, 12'h000, 1, 0, 0);
    chk_out("stall_hold", ev(0, 0, 12'h000, 1, 0, 3'd2));
    tick(); drive(0, 12'h000, 0, 0, 0);
    chk_out("stall_release", ev(1, 0, 12'h000, 0, 0, 3'd2));
    tick(); drive(0, 12'h000, 0, 0, 0);
    chk_out("stall_run", ev(1, 0, 12'h000, 0, 0, 3'd1));

    // Branch beats halt.
    drive(1, 12'h123, 0, 1, 0);
    chk_out("br_over_halt", ev(1, 1, 12'h123, 0, 1, 3'd1));
    tick(); drive(0, 12'h000, 0, 0, 0);
    chk_out("bh_flush", ev(1, 0, 12'h000, 0, 1, 3'd3));
    chk("bh_cnt3", 32'(redirect_cnt), 32'd3);
    tick(); drive(0, 12'h000, 0, 0, 0);

    // Halt alone, events ignored, resume.
    drive(0, 12'h000, 0, 1, 0);
    chk_out("halt_enter", ev(0, 0, 12'h000, 0, 1, 3'd1));
    tick(); drive(1, 12'h055, 1, 1, 0);
    chk_out("halt_ignore", ev(0, 0, 12'h000, 1, 0, 3'd4));
    tick(); drive(0, 12'h000, 0, 0, 1);
    chk_out("halt_resume", ev(0, 0, 12'h000, 1, 0, 3'd4));
    chk("halt_cnt3", 32'(redirect_cnt), 32'd3);
    tick(); drive(0, 12'h000, 0, 0, 0);
    chk_out("halt_run", ev(1, 0, 12'h000, 0, 0, 3'd1));

    // Back-to-back redirects to saturation.
    drive(1, 12'h3C3, 0, 0, 0);
    for (int i = 0; i < 252; i++) tick();
    chk_out("sat_reload", ev(1, 1, 12'h3C3, 0, 1, 3'd3));
    chk("sat_255", 32'(redirect_cnt), 32'd255);
    for (int i = 0; i < 8; i++) tick();
    chk("sat_hold", 32'(redirect_cnt), 32'd255);
    drive(0, 12'h000, 0, 0, 0);
    chk_out("sat_flush", ev(1, 0, 12'h000, 0, 1, 3'd3));
    tick(); drive(0, 12'h000, 0, 0, 0);
    chk_out("sat_run", ev(1, 0, 12'h000, 0, 0, 3'd1));

    // Reset in the first FLUSH cycle.
    drive(1, 12'h777, 0, 0, 0);
    tick(); drive(0, 12'h000, 0, 0, 0);
    chk_out("rf_flush", ev(1, 0, 12'h000, 0, 1, 3'd3));
    rst = 1'b0;
    #1;
    chk_out("rf_async", ev(0, 0, 12'h000, 0, 1, 3'd0));
    chk("rf_cnt0", 32'(redirect_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_out("rf_boot", ev(0, 0, 12'h000, 0, 1, 3'd0));
    tick(); drive(0, 12'h000, 0, 0, 0);
    chk_out("rf_run0", ev(1, 0, 12'h000, 0, 0, 3'd1));
    tick(); drive(0, 12'h000, 0, 0, 0);
    chk_out("rf_run1", ev(1, 0, 12'h000, 0, 0, 3'd1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
